reg_byte_load_seq: RTL and testbench

- Sequencer that assembles a 32-bit value in a Register32bit-style register from a byte-wide memory.
- Fetches 1-4 consecutive bytes over a req/ack handshake.
- Drives the register's E/FunSel/I so the first byte lands zero-extended and each later byte shifts in at the LSB (big-endian assembly).
- Sits between the control unit (Start/Busy/Done/Err) and the byte memory plus the target register (IR or AR class).

---
 rtl/reg_byte_load_seq_pkg.sv | 27 ++
 rtl/reg_byte_load_seq.sv | 128 ++++++++++++
 tb/tb_reg_byte_load_seq.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_byte_load_seq_pkg.sv
// Shared definitions for the byte-load sequencer: the target register's
// function-select codes and the sequencer state encoding.
package reg_byte_load_seq_pkg;

  typedef enum logic [2:0] {
    FS_DEC    = 3'b000,
    FS_INC    = 3'b001,
    FS_LOAD   = 3'b010,
    FS_CLR    = 3'b011,
    FS_LOAD8  = 3'b100,
    FS_LOAD16 = 3'b101,
    FS_SHL8   = 3'b110,
    FS_SEXT16 = 3'b111
  } funsel_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_LOAD = 3'd2,
    ST_CLR  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  localparam int MAX_BYTES = 4;

endpackage

// File: rtl/reg_byte_load_seq.sv
// Fetches 1-4 bytes from a byte memory and assembles them big-endian into a
// 32-bit register by issuing LOAD8 for the first byte and SHL8 for the rest.
module reg_byte_load_seq
  import reg_byte_load_seq_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [2:0]        ByteCount,
  output logic              MemReq,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic              MemAck,
  input  logic [7:0]        MemData,
  output logic              RegE,
  output logic [2:0]        RegFunSel,
  output logic [31:0]       RegI,
  output logic              Busy,
  output logic              Done,
  output logic              Err
);

  localparam int TIMER_W = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [2:0]          count_q, count_d;
  logic [2:0]          index_q, index_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [7:0]          byte_q, byte_d;
  logic [2:0]          index_inc;
  logic [TIMER_W-1:0]  timer_cnt;

  // timer_q holds completed no-ack REQ cycles, so timer_cnt is the 1-based
  // count of the REQ cycle currently in progress.
  assign index_inc = index_q + 3'd1;
  assign timer_cnt = timer_q + TIMER_W'(1);
  assign RegI      = {24'b0, byte_q};

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      count_q <= '0;
      index_q <= '0;
      timer_q <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      index_q <= index_d;
      timer_q <= timer_d;
      byte_q  <= byte_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    count_d   = count_q;
    index_d   = index_q;
    timer_d   = timer_q;
    byte_d    = byte_q;
    MemReq    = 1'b0;
    MemAddr   = '0;
    RegE      = 1'b0;
    RegFunSel = FS_DEC;
    Done      = 1'b0;
    Err       = 1'b0;
    Busy      = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          base_d  = BaseAddr;
          count_d = ByteCount;
          index_d = '0;
          timer_d = '0;
          if (ByteCount == 3'd0)
            state_d = ST_CLR;
          else if (ByteCount <= 3'(MAX_BYTES))
            state_d = ST_REQ;
          else
            state_d = ST_ERR;
        end
      end
      ST_REQ: begin
        MemReq  = 1'b1;
        MemAddr = base_q + ADDR_W'(index_q);
        // An ack on the final allowed cycle still wins over the timeout.
        if (MemAck) begin
          byte_d  = MemData;
          state_d = ST_LOAD;
        end else if (timer_cnt == TIMER_W'(TIMEOUT)) begin
          state_d = ST_ERR;
        end else begin
          timer_d = timer_cnt;
        end
      end
      ST_LOAD: begin
        RegE      = 1'b1;
        RegFunSel = (index_q == 3'd0) ? FS_LOAD8 : FS_SHL8;
        index_d   = index_inc;
        timer_d   = '0;
        state_d   = (index_inc == count_q) ? ST_DONE : ST_REQ;
      end
      ST_CLR: begin
        RegE      = 1'b1;
        RegFunSel = FS_CLR;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        Done    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        Err     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_byte_load_seq.sv
// Bench for reg_byte_load_seq: a 32-bit register model, a byte memory responder
// with programmable ack delays, directed vectors and randomized transactions.
module tb_reg_byte_load_seq;

  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 15;
  localparam int LIMIT   = 120;

  logic              Clock = 1'b0;
  logic              Reset = 1'b0;
  logic              Start = 1'b0;
  logic [ADDR_W-1:0] BaseAddr = '0;
  logic [2:0]        ByteCount = '0;
  logic              MemReq;
  logic [ADDR_W-1:0] MemAddr;
  logic              MemAck = 1'b0;
  logic [7:0]        MemData = '0;
  logic              RegE;
  logic [2:0]        RegFunSel;
  logic [31:0]       RegI;
  logic              Busy;
  logic              Done;
  logic              Err;

  int checks = 0;
  int errors = 0;

  reg_byte_load_seq #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .BaseAddr(BaseAddr),
    .ByteCount(ByteCount), .MemReq(MemReq), .MemAddr(MemAddr),
    .MemAck(MemAck), .MemData(MemData), .RegE(RegE), .RegFunSel(RegFunSel),
    .RegI(RegI), .Busy(Busy), .Done(Done), .Err(Err)
  );

  always #5 Clock = ~Clock;

  // Target register: behaves like Register32bit, with a bench-only preload path.
  logic [31:0] regQ;
  logic        preloadEn = 1'b0;
  logic [31:0] preloadVal = '0;

  always @(posedge Clock) begin
    if (preloadEn) regQ <= preloadVal;
    else if (RegE) begin
      case (RegFunSel)
        3'b000: regQ <= regQ - 32'd1;
        3'b001: regQ <= regQ + 32'd1;
        3'b010: regQ <= RegI;
        3'b011: regQ <= 32'd0;
        3'b100: regQ <= {24'd0, RegI[7:0]};
        3'b101: regQ <= {16'd0, RegI[15:0]};
        3'b110: regQ <= {regQ[23:0], RegI[7:0]};
        default: regQ <= {{16{RegI[15]}}, RegI[15:0]};
      endcase
    end
  end

  // Memory responder: request number rspIdx is acked after rspDelay[rspIdx] wait cycles.
  logic [7:0]        mem [0:65535];
  int                rspDelay [4];
  int                rspIdx = 0;
  int                rspWait = 0;
  logic              spuriousAck = 1'b0;
  logic [ADDR_W-1:0] addrLog [$];

  always @(negedge Clock) begin
    if (MemReq) begin
      if (rspIdx < 4 && rspWait == rspDelay[rspIdx]) begin
        MemAck = 1'b1;
        MemData = mem[MemAddr];
        addrLog.push_back(MemAddr);
        rspIdx++;
        rspWait = 0;
      end else begin
        MemAck = 1'b0;
        MemData = 8'($urandom);
        rspWait++;
      end
    end else begin
      MemAck = spuriousAck & 1'($urandom_range(0, 1));
      MemData = 8'hEE;
      rspWait = 0;
    end
  end

  typedef struct {
    string       name;
    logic [15:0] base;
    logic [2:0]  cnt;
    logic [31:0] bytes;
    logic [31:0] delays;
    logic [31:0] preload;
    logic [31:0] expQ;
    int          expDone;
    int          expErr;
    int          expReq;
    int          expRegE;
    int          expHs;
  } vec_t;

  vec_t vecs [$];

  task automatic addVec(input string name, input logic [15:0] base, input logic [2:0] cnt,
                        input logic [31:0] bytes, input logic [31:0] delays,
                        input logic [31:0] preload, input logic [31:0] expQ,
                        input int expDone, input int expErr, input int expReq,
                        input int expRegE, input int expHs);
    vec_t v;
    v.name = name; v.base = base; v.cnt = cnt; v.bytes = bytes; v.delays = delays;
    v.preload = preload; v.expQ = expQ; v.expDone = expDone; v.expErr = expErr;
    v.expReq = expReq; v.expRegE = expRegE; v.expHs = expHs;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic preloadReg(input logic [31:0] val);
    @(negedge Clock);
    preloadEn = 1'b1;
    preloadVal = val;
    @(posedge Clock);
    #1 preloadEn = 1'b0;
  endtask

  // Pulses Start and watches until Done/Err or LIMIT cycles; cycle 1 follows the Start edge.
  task automatic applyStimulus(input logic [15:0] base, input logic [2:0] cnt,
                               output int doneCyc, output int errCyc, output int reqCnt,
                               output int regeCnt, output logic busyOk);
    @(negedge Clock);
    rspIdx = 0;
    addrLog.delete();
    Start = 1'b1;
    BaseAddr = base;
    ByteCount = cnt;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    BaseAddr = 16'($urandom);
    ByteCount = 3'($urandom);
    doneCyc = -1; errCyc = -1; reqCnt = 0; regeCnt = 0; busyOk = 1'b1;
    for (int k = 1; k <= LIMIT; k++) begin
      @(negedge Clock);
      if (MemReq) reqCnt++;
      if (RegE) regeCnt++;
      if (!Busy) busyOk = 1'b0;
      if (Done) doneCyc = k;
      if (Err) errCyc = k;
      if (Done || Err) break;
    end
  endtask

  task automatic verifyTxn(input string name, input logic [15:0] base,
                           input logic [31:0] expQ, input int expDone, input int expErr,
                           input int expReq, input int expRegE, input int expHs,
                           input int doneCyc, input int errCyc, input int reqCnt,
                           input int regeCnt, input logic busyOk);
    logic addrOk;
    addrOk = 1'b1;
    foreach (addrLog[i])
      if (addrLog[i] !== base + 16'(i)) addrOk = 1'b0;
    checkOutput({name, " regQ"}, regQ, expQ);
    checkOutput({name, " doneCycle"}, doneCyc, expDone);
    checkOutput({name, " errCycle"}, errCyc, expErr);
    checkOutput({name, " memReqCycles"}, reqCnt, expReq);
    checkOutput({name, " regECycles"}, regeCnt, expRegE);
    checkOutput({name, " handshakes"}, addrLog.size(), expHs);
    checkOutput({name, " addresses"}, {31'd0, addrOk}, 32'd1);
    checkOutput({name, " busyThrough"}, {31'd0, busyOk}, 32'd1);
    @(negedge Clock);
    checkOutput({name, " idleAfter"}, {29'd0, Busy, Done, Err}, 32'd0);
  endtask

  // Reference: transaction outcome from the memory contents and ack delays alone.
  task automatic modelTxn(input logic [15:0] base, input logic [2:0] cnt, input logic [31:0] qBefore,
                          output logic [31:0] expQ, output int expDone, output int expErr,
                          output int expReq, output int expRegE, output int expHs);
    int cyc;
    expQ = qBefore; expDone = -1; expErr = -1; expReq = 0; expRegE = 0; expHs = 0;
    cyc = 0;
    if (cnt > 3'd4) expErr = 1;
    else if (cnt == 3'd0) begin
      expQ = 32'd0; expDone = 2; expRegE = 1;
    end else begin
      for (int i = 0; i < int'(cnt); i++) begin
        if (rspDelay[i] >= TIMEOUT) begin
          expReq += TIMEOUT;
          expErr = cyc + TIMEOUT + 1;
          break;
        end
        expReq += rspDelay[i] + 1;
        cyc += rspDelay[i] + 2;
        expHs++;
        expRegE++;
        if (i == 0) expQ = {24'd0, mem[base + 16'(i)]};
        else expQ = (expQ << 8) | {24'd0, mem[base + 16'(i)]};
      end
      if (expErr < 0) expDone = cyc + 1;
    end
  endtask

  initial begin
    int dc, ec, rc, gc, eDone, eErr, eReq, eRegE, eHs;
    logic bo;
    logic [31:0] eQ, qBefore;
    logic [15:0] base;
    logic [2:0] cnt;
    logic sawPulse;

    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 4; i++) rspDelay[i] = 0;

    // Reset state
    #1;
    checkOutput("reset MemReq", {31'd0, MemReq}, 32'd0);
    checkOutput("reset RegE", {31'd0, RegE}, 32'd0);
    checkOutput("reset Busy/Done/Err", {29'd0, Busy, Done, Err}, 32'd0);
    checkOutput("reset RegFunSel", {29'd0, RegFunSel}, 32'd0);
    checkOutput("reset MemAddr", {16'd0, MemAddr}, 32'd0);
    checkOutput("reset RegI", RegI, 32'd0);
    repeat (2) @(negedge Clock);
    Reset = 1'b1;

    addVec("load4",    16'h0010, 3'd4, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 32'h12345678,  9, -1,  4, 4, 4);
    addVec("wrap2",    16'hFFFF, 3'd2, 32'hABCD0000, 32'h00000000, 32'hDEADBEEF, 32'h0000ABCD,  5, -1,  2, 2, 2);
    addVec("clear",    16'h1234, 3'd0, 32'h00000000, 32'h00000000, 32'hDEADBEEF, 32'h00000000,  2, -1,  0, 1, 0);
    addVec("illegal6", 16'h0020, 3'd6, 32'h00000000, 32'h00000000, 32'hCAFEF00D, 32'hCAFEF00D, -1,  1,  0, 0, 0);
    addVec("illegal7", 16'h0030, 3'd7, 32'h00000000, 32'h00000000, 32'h0BADF00D, 32'h0BADF00D, -1,  1,  0, 0, 0);
    addVec("timeout3", 16'h0200, 3'd3, 32'h5A771100, 32'h00FF0000, 32'h11111111, 32'h0000005A, -1, 18, 16, 1, 1);
    addVec("ackLast",  16'h0300, 3'd1, 32'h9C000000, 32'h0E000000, 32'hFFFFFFFF, 32'h0000009C, 17, -1, 15, 1, 1);
    addVec("ackLate",  16'h0310, 3'd1, 32'h9C000000, 32'h0F000000, 32'h87654321, 32'h87654321, -1, 16, 15, 0, 0);
    addVec("waits3",   16'h0400, 3'd3, 32'hA1B2C300, 32'h01000200, 32'h00000000, 32'h00A1B2C3, 10, -1,  6, 3, 3);

    foreach (vecs[n]) begin
      for (int i = 0; i < 4; i++) begin
        mem[vecs[n].base + 16'(i)] = vecs[n].bytes[31 - 8*i -: 8];
        rspDelay[i] = int'(vecs[n].delays[31 - 8*i -: 8]);
      end
      preloadReg(vecs[n].preload);
      applyStimulus(vecs[n].base, vecs[n].cnt, dc, ec, rc, gc, bo);
      verifyTxn(vecs[n].name, vecs[n].base, vecs[n].expQ, vecs[n].expDone, vecs[n].expErr,
                vecs[n].expReq, vecs[n].expRegE, vecs[n].expHs, dc, ec, rc, gc, bo);
    end

    // Start held across the DONE cycle: ignored there, accepted on the first IDLE cycle.
    mem[16'h0500] = 8'h3C;
    for (int i = 0; i < 4; i++) rspDelay[i] = 0;
    preloadReg(32'hFFFFFFFF);
    applyStimulus(16'h0500, 3'd1, dc, ec, rc, gc, bo);
    checkOutput("doneStart doneCycle", dc, 32'd3);
    checkOutput("doneStart regQ", regQ, 32'h0000003C);
    Start = 1'b1;
    ByteCount = 3'd0;
    @(negedge Clock);
    checkOutput("doneStart ignoredInDone", {31'd0, Busy}, 32'd0);
    @(posedge Clock);
    #1 Start = 1'b0;
    @(negedge Clock);
    checkOutput("doneStart clrCycle", {28'd0, Busy, RegE, RegFunSel[1:0]}, 32'hF);
    checkOutput("doneStart clrFunSel", {29'd0, RegFunSel}, 32'd3);
    @(negedge Clock);
    checkOutput("doneStart clrDone", {31'd0, Done}, 32'd1);
    checkOutput("doneStart clrQ", regQ, 32'd0);

    // Reset in REQ of byte 3, after a Start pulse while busy.
    for (int i = 0; i < 4; i++) mem[16'h0100 + 16'(i)] = 8'(8'h11 * (i + 1));
    preloadReg(32'd0);
    @(negedge Clock);
    rspIdx = 0;
    addrLog.delete();
    Start = 1'b1; BaseAddr = 16'h0100; ByteCount = 3'd4;
    @(posedge Clock);
    #1 Start = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    Start = 1'b1; ByteCount = 3'd0;
    @(posedge Clock);
    #1 Start = 1'b0;
    repeat (3) @(negedge Clock);
    checkOutput("abort inReqByte3", {15'd0, MemReq, MemAddr}, {15'd0, 1'b1, 16'h0102});
    Reset = 1'b0;
    #1;
    checkOutput("abort outputsLow", {27'd0, MemReq, Busy, Done, Err, RegE}, 32'd0);
    checkOutput("abort regQ", regQ, 32'h00001122);
    sawPulse = 1'b0;
    repeat (2) @(negedge Clock) if (Done || Err || Busy) sawPulse = 1'b1;
    Reset = 1'b1;
    repeat (4) @(negedge Clock) if (Done || Err || Busy) sawPulse = 1'b1;
    checkOutput("abort noPulseAfter", {31'd0, sawPulse}, 32'd0);
    checkOutput("abort regQHeld", regQ, 32'h00001122);

    // Randomized transactions against the reference model.
    spuriousAck = 1'b1;
    for (int t = 0; t < 30; t++) begin
      base = 16'($urandom);
      cnt = 3'($urandom_range(0, 7));
      qBefore = $urandom;
      for (int i = 0; i < 4; i++)
        rspDelay[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 3));
      preloadReg(qBefore);
      modelTxn(base, cnt, qBefore, eQ, eDone, eErr, eReq, eRegE, eHs);
      applyStimulus(base, cnt, dc, ec, rc, gc, bo);
      verifyTxn($sformatf("rand%0d", t), base, eQ, eDone, eErr, eReq, eRegE, eHs, dc, ec, rc, gc, bo);
    end
    spuriousAck = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
